// File: rtl/ext_int_pkg.sv
// Shared register map and VEC layout for the external interrupt controller.
package ext_int_pkg;
    localparam int ADDR_GER      = 0;
    localparam int ADDR_IER_RISE = 1;
    localparam int ADDR_IER_FALL = 2;
    localparam int ADDR_ISR      = 3;
    localparam int ADDR_PIN      = 4;
    localparam int ADDR_LVL_EN   = 5;
    localparam int ADDR_LVL_POL  = 6;
    localparam int ADDR_VEC      = 7;
    localparam int ADDR_DEBOUNCE = 8;

    localparam int VEC_IDX_W = 5;

    // The "any pending" flag in VEC is the top data bit.
    function automatic int vec_vld_pos(input int dw);
        return dw - 1;
    endfunction
endpackage

// File: rtl/ext_int_chan.sv
// One interrupt channel: pin synchroniser, debounce filter and edge detection.
module ext_int_chan
    import ext_int_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTw       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pin,
    input  logic [FILTw-1:0] deb,
    input  logic             deb_clr,
    output logic             f,
    output logic             rise,
    output logic             fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   p;
    logic [FILTw-1:0]       cnt;

    assign sync = sync_q[SYNC_STAGES-1];
    assign rise = f & ~p;
    assign fall = ~f & p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            f      <= 1'b0;
            p      <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            p      <= f;
            // cnt never exceeds deb-1, so the all-ones debounce value cannot wrap.
            if (deb <= FILTw'(1)) begin
                f   <= sync;
                cnt <= '0;
            end else if (sync == f) begin
                cnt <= '0;
            end else if (cnt == deb - FILTw'(1)) begin
                f   <= ~f;
                cnt <= '0;
            end else begin
                cnt <= cnt + FILTw'(1);
            end
            if (deb_clr)
                cnt <= '0;
        end
    end
endmodule

// File: rtl/ext_int_filt.sv
// Wishbone-slave external interrupt controller with per-channel edge/level
// selection, debounce filtering and a lowest-index pending vector.
module ext_int_filt
    import ext_int_pkg::*;
#(
    parameter int EXT_INT_NUM = 8,
    parameter int Aw          = 4,
    parameter int SELw        = 4,
    parameter int TAGw        = 3,
    parameter int Dw          = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILTw       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [Dw-1:0]          sa_dat_i,
    input  logic [SELw-1:0]        sa_sel_i,
    input  logic [Aw-1:0]          sa_addr_i,
    input  logic [TAGw-1:0]        sa_tag_i,
    input  logic                   sa_stb_i,
    input  logic                   sa_cyc_i,
    input  logic                   sa_we_i,
    output logic [Dw-1:0]          sa_dat_o,
    output logic                   sa_ack_o,
    output logic                   sa_err_o,
    output logic                   sa_rty_o,
    input  logic [EXT_INT_NUM-1:0] ext_int_i,
    output logic                   ext_int_o
);
    localparam int N       = EXT_INT_NUM;
    localparam int VEC_VLD = vec_vld_pos(Dw);

    logic             ger;
    logic [N-1:0]     ier_rise, ier_fall, isr, lvl_en, lvl_pol;
    logic [FILTw-1:0] debounce;
    logic [N-1:0]     f, rise, fall, set, w1c;
    logic             req, wr, rd, wr_deb;
    logic [Dw-1:0]    rdata;
    logic [VEC_IDX_W-1:0] vec_idx;
    logic             unused_bus;

    assign unused_bus = ^{sa_sel_i, sa_tag_i, sa_dat_i};

    assign req    = sa_stb_i & sa_cyc_i & ~sa_ack_o;
    assign wr     = req & sa_we_i;
    assign rd     = req & ~sa_we_i;
    assign wr_deb = wr && (sa_addr_i == Aw'(ADDR_DEBOUNCE));

    assign sa_err_o  = 1'b0;
    assign sa_rty_o  = 1'b0;
    assign ext_int_o = |isr;

    for (genvar i = 0; i < N; i++) begin : g_chan
        ext_int_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTw      (FILTw)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .pin    (ext_int_i[i]),
            .deb    (debounce),
            .deb_clr(wr_deb),
            .f      (f[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    // Level channels ignore their edge enables; GER gates every new set.
    assign set = ger ? ((lvl_en & ~(f ^ lvl_pol)) |
                        (~lvl_en & ((ier_rise & rise) | (ier_fall & fall)))) : '0;
    assign w1c = (wr && sa_addr_i == Aw'(ADDR_ISR)) ? sa_dat_i[N-1:0] : '0;

    always_comb begin
        vec_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (isr[i]) vec_idx = VEC_IDX_W'(i);
    end

    always_comb begin
        rdata = '0;
        case (sa_addr_i)
            Aw'(ADDR_GER):      rdata[0] = ger;
            Aw'(ADDR_IER_RISE): rdata[N-1:0] = ier_rise;
            Aw'(ADDR_IER_FALL): rdata[N-1:0] = ier_fall;
            Aw'(ADDR_ISR):      rdata[N-1:0] = isr;
            Aw'(ADDR_PIN):      rdata[N-1:0] = f;
            Aw'(ADDR_LVL_EN):   rdata[N-1:0] = lvl_en;
            Aw'(ADDR_LVL_POL):  rdata[N-1:0] = lvl_pol;
            Aw'(ADDR_VEC): begin
                rdata[VEC_IDX_W-1:0] = vec_idx;
                rdata[VEC_VLD]       = |isr;
            end
            Aw'(ADDR_DEBOUNCE): rdata[FILTw-1:0] = debounce;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa_ack_o <= 1'b0;
            sa_dat_o <= '0;
            ger      <= 1'b0;
            ier_rise <= '0;
            ier_fall <= '0;
            isr      <= '0;
            lvl_en   <= '0;
            lvl_pol  <= '0;
            debounce <= '0;
        end else begin
            sa_ack_o <= req;
            if (rd)
                sa_dat_o <= rdata;
            // Set wins over a same-cycle write-1-to-clear.
            isr <= (isr & ~w1c) | set;
            if (wr) begin
                case (sa_addr_i)
                    Aw'(ADDR_GER):      ger      <= sa_dat_i[0];
                    Aw'(ADDR_IER_RISE): ier_rise <= sa_dat_i[N-1:0];
                    Aw'(ADDR_IER_FALL): ier_fall <= sa_dat_i[N-1:0];
                    Aw'(ADDR_LVL_EN):   lvl_en   <= sa_dat_i[N-1:0];
                    Aw'(ADDR_LVL_POL):  lvl_pol  <= sa_dat_i[N-1:0];
                    Aw'(ADDR_DEBOUNCE): debounce <= sa_dat_i[FILTw-1:0];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ext_int_filt.sv
// Directed scenarios plus random pin/bus traffic against a cycle-level reference model.
module tb_ext_int_filt;
    localparam int N = 8, AW = 4, DW = 32, S = 2, FW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] sa_dat_i;
    logic [3:0]    sa_sel_i;
    logic [AW-1:0] sa_addr_i;
    logic [2:0]    sa_tag_i;
    logic          sa_stb_i, sa_cyc_i, sa_we_i;
    logic [DW-1:0] sa_dat_o;
    logic          sa_ack_o, sa_err_o, sa_rty_o;
    logic [N-1:0]  ext_int_i;
    logic          ext_int_o;

    always #5 clk = ~clk;

    ext_int_filt #(
        .EXT_INT_NUM(N), .Aw(AW), .SELw(4), .TAGw(3), .Dw(DW),
        .SYNC_STAGES(S), .FILTw(FW)
    ) dut (
        .clk(clk), .reset(reset),
        .sa_dat_i(sa_dat_i), .sa_sel_i(sa_sel_i), .sa_addr_i(sa_addr_i),
        .sa_tag_i(sa_tag_i), .sa_stb_i(sa_stb_i), .sa_cyc_i(sa_cyc_i),
        .sa_we_i(sa_we_i), .sa_dat_o(sa_dat_o), .sa_ack_o(sa_ack_o),
        .sa_err_o(sa_err_o), .sa_rty_o(sa_rty_o),
        .ext_int_i(ext_int_i), .ext_int_o(ext_int_o)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: state as the specification describes it.
    bit           m_ger, m_ack;
    bit [N-1:0]   m_ren, m_fen, m_isr, m_lvl, m_pol, m_f, m_p;
    int           m_deb;
    int           run[N];          // consecutive cycles the synchronised pin disagreed with f
    logic [N-1:0] pin_hist[$];     // pin samples still travelling through the synchroniser
    logic [31:0]  m_rdata;

    function automatic void m_reset();
        m_ger = 0; m_ack = 0; m_ren = 0; m_fen = 0; m_isr = 0; m_lvl = 0; m_pol = 0;
        m_f = 0; m_p = 0; m_deb = 0; m_rdata = 0;
        foreach (run[c]) run[c] = 0;
        pin_hist = {};
        repeat (S) pin_hist.push_back('0);
    endfunction

    function automatic logic [31:0] m_read(input int a);
        case (a)
            0: return 32'(m_ger);
            1: return 32'(m_ren);
            2: return 32'(m_fen);
            3: return 32'(m_isr);
            4: return 32'(m_f);
            5: return 32'(m_lvl);
            6: return 32'(m_pol);
            7: begin
                for (int i = 0; i < N; i++)
                    if (m_isr[i]) return 32'h8000_0000 | 32'(i);
                return 0;
            end
            8: return 32'(m_deb);
            default: return 0;
        endcase
    endfunction

    function automatic void m_edge();
        bit           req;
        bit [N-1:0]   set, w1c, nf;
        logic [N-1:0] sync;
        int           a;
        req  = sa_stb_i && sa_cyc_i && !m_ack;
        a    = int'(sa_addr_i);
        sync = pin_hist[0];
        set  = 0; w1c = 0; nf = m_f;
        for (int c = 0; c < N; c++) begin
            if (m_ger) begin
                if (m_lvl[c]) set[c] = (m_f[c] == m_pol[c]);
                else set[c] = (m_ren[c] && m_f[c] && !m_p[c]) || (m_fen[c] && !m_f[c] && m_p[c]);
            end
            if (m_deb <= 1) begin
                nf[c] = sync[c]; run[c] = 0;
            end else if (sync[c] == m_f[c]) begin
                run[c] = 0;
            end else begin
                run[c]++;
                if (run[c] >= m_deb) begin nf[c] = !m_f[c]; run[c] = 0; end
            end
        end
        if (req && !sa_we_i) m_rdata = m_read(a);
        if (req && sa_we_i) begin
            case (a)
                0: m_ger = sa_dat_i[0];
                1: m_ren = sa_dat_i[N-1:0];
                2: m_fen = sa_dat_i[N-1:0];
                3: w1c   = sa_dat_i[N-1:0];
                5: m_lvl = sa_dat_i[N-1:0];
                6: m_pol = sa_dat_i[N-1:0];
                8: begin m_deb = int'(sa_dat_i[FW-1:0]); foreach (run[c]) run[c] = 0; end
                default: ;
            endcase
        end
        m_isr = (m_isr & ~w1c) | set;
        m_p   = m_f;
        m_f   = nf;
        void'(pin_hist.pop_front());
        pin_hist.push_back(ext_int_i);
        m_ack = req;
    endfunction

    task automatic step();
        @(posedge clk);
        if (reset) m_reset(); else m_edge();
        @(negedge clk);
        chk("int_o", ext_int_o, 32'(|m_isr));
    endtask

    task automatic bus(input bit we, input int a, input logic [31:0] d);
        sa_stb_i = 1; sa_cyc_i = 1; sa_we_i = we; sa_addr_i = AW'(a); sa_dat_i = d;
        step();
        chk("ack", sa_ack_o, 1);
        if (!we) chk($sformatf("rdata@%0d", a), sa_dat_o, m_rdata);
        sa_stb_i = 0; sa_cyc_i = 0; sa_we_i = 0;
        step();
        chk("ack_one_cycle", sa_ack_o, 0);
    endtask

    task automatic rd_exp(input string tag, input int a, input logic [31:0] exp);
        bus(0, a, 0);
        chk(tag, sa_dat_o, exp);
    endtask

    int r, a;
    logic [31:0] d;

    initial begin
        reset = 1; sa_dat_i = 0; sa_sel_i = 4'hF; sa_addr_i = 0; sa_tag_i = 0;
        sa_stb_i = 0; sa_cyc_i = 0; sa_we_i = 0; ext_int_i = 0;
        m_reset();
        #1;
        chk("rst_dat", sa_dat_o, 0);
        chk("rst_ack", sa_ack_o, 0);
        chk("rst_int", ext_int_o, 0);
        chk("err_rty", {sa_err_o, sa_rty_o}, 0);
        step(); step();
        reset = 0;
        for (int i = 0; i <= 8; i++) rd_exp($sformatf("rst_reg%0d", i), i, 0);
        rd_exp("unmapped", 15, 0);

        // Rising edge, no debounce: 4-edge latency.
        bus(1, 0, 1); bus(1, 1, 32'h01); bus(1, 8, 0);
        ext_int_i[0] = 1;
        repeat (3) step();
        chk("rise_early", ext_int_o, 0);
        step();
        chk("rise_lat", ext_int_o, 1);
        rd_exp("isr_rise", 3, 32'h01);
        rd_exp("vec_rise", 7, 32'h8000_0000);
        bus(1, 3, 32'h01);
        chk("w1c_int", ext_int_o, 0);

        // Debounce 5 on a falling channel.
        bus(1, 8, 5); bus(1, 2, 32'h04);
        ext_int_i[2] = 1;
        repeat (12) step();
        ext_int_i[2] = 0;
        repeat (3) step();
        ext_int_i[2] = 1;
        repeat (12) step();
        rd_exp("glitch", 3, 0);
        ext_int_i[2] = 0;
        repeat (7) step();
        chk("fall_early", ext_int_o, 0);
        step();
        chk("fall_lat", ext_int_o, 1);
        ext_int_i[2] = 1;
        rd_exp("isr_fall", 3, 32'h04);
        bus(1, 3, 32'h04);
        repeat (10) step();

        // Active-low level channel re-asserts after clear.
        bus(1, 6, 0); bus(1, 5, 32'h08);
        bus(1, 3, 32'h08);
        rd_exp("lvl_reassert", 3, 32'h08);
        ext_int_i[3] = 1;
        repeat (10) step();
        bus(1, 3, 32'h08);
        rd_exp("lvl_cleared", 3, 0);

        // Priority vector.
        bus(1, 1, 32'h21);
        ext_int_i[5] = 1; repeat (10) step();
        ext_int_i[2] = 0; repeat (10) step();
        rd_exp("vec_2", 7, 32'h8000_0002);
        bus(1, 3, 32'h04);
        rd_exp("vec_5", 7, 32'h8000_0005);
        bus(1, 3, 32'h20);
        rd_exp("isr_empty", 3, 0);

        // Set beats a same-cycle clear.
        bus(1, 8, 0);
        ext_int_i[0] = 0; repeat (5) step();
        ext_int_i[0] = 1; repeat (3) step();
        bus(1, 3, 32'h01);
        rd_exp("set_wins", 3, 32'h01);

        // GER=0 blocks sets, keeps pending bits.
        bus(1, 0, 0);
        ext_int_i[5] = 0; repeat (5) step();
        ext_int_i[5] = 1; repeat (6) step();
        rd_exp("ger_off", 3, 32'h01);
        bus(1, 0, 1);
        rd_exp("ger_keep", 3, 32'h01);

        // Maximum debounce value.
        bus(1, 3, 32'hFF); bus(1, 1, 32'h02); bus(1, 8, 255);
        ext_int_i[1] = 1;
        repeat (257) step();
        chk("dmax_early", ext_int_o, 0);
        step();
        chk("dmax_lat", ext_int_o, 1);
        rd_exp("dmax_isr", 3, 32'h02);
        rd_exp("dmax_reg", 8, 255);

        // Random traffic checked against the model.
        bus(1, 8, 2);
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                if ($urandom_range(0, 2) == 0) ext_int_i = ext_int_i ^ N'($urandom);
                step();
            end else if (r < 8) begin
                a = $urandom_range(0, 8);
                d = $urandom;
                if (a == 8) d = $urandom_range(0, 6);
                if (a == 0) d = ($urandom_range(0, 3) != 0) ? 1 : 0;
                bus(1, a, d);
            end else begin
                bus(0, $urandom_range(0, 15), 0);
            end
        end

        // Reset during a write drops the cycle.
        sa_stb_i = 1; sa_cyc_i = 1; sa_we_i = 1; sa_addr_i = AW'(2); sa_dat_i = 32'hFF;
        #2 reset = 1;
        #1 chk("rst_async_int", ext_int_o, 0);
        step();
        chk("rst_ack_drop", sa_ack_o, 0);
        sa_stb_i = 0; sa_cyc_i = 0; sa_we_i = 0;
        reset = 0;
        rd_exp("rst_mid_write", 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
